// File: rtl/serializer_pkg.sv
// Shared constants and state type for the histogram readout serializer.
package serializer_pkg;

  localparam int SER_DATA_WIDTH = 24;
  localparam int SER_CNT_W      = $clog2(SER_DATA_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/data_serializer_if.sv
// Word-in / bit-out bundle between the histogram sequencer (master) and the serializer (slave).
interface data_serializer_if
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data_in;
  logic                  serial_out;
  logic                  slow_clk_out;
  logic                  done;

  modport master (
    output data_in,
    input  serial_out,
    input  slow_clk_out,
    input  done
  );

  modport slave (
    input  data_in,
    output serial_out,
    output slow_clk_out,
    output done
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Modulo-DATA_WIDTH bit counter; last_bit and first_half are registered decodes of the count.
module ser_bit_counter
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic last_bit,
  output logic first_half
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt + CNT_W'(1);
    if (restart || last_bit) begin
      cnt_d = '0;
    end
  end

  // Flags are decoded from the next count and registered, so the outputs come straight off flops.
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt        <= '0;
      last_bit   <= 1'b0;
      first_half <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      last_bit   <= (cnt_d == CNT_W'(DATA_WIDTH - 1));
      first_half <= (cnt_d < CNT_W'(DATA_WIDTH / 2));
    end
  end

endmodule

// File: rtl/data_serializer.sv
// Parallel-to-serial converter for the histogram readout path, streaming back-to-back words.
// Define SERIALIZER_LSB_FIRST_EN to shift words out LSB first (default: MSB first).
module data_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH
) (
  input  logic              fast_clk_in,
  input  logic              reset,
  data_serializer_if.slave  bus
);

  if ((DATA_WIDTH < 2) || (DATA_WIDTH % 2 != 0)) begin : g_width_check
    $error("data_serializer: DATA_WIDTH must be even and at least 2");
  end

  ser_state_e            state;
  ser_state_e            state_d;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  last_bit;
  logic                  first_half;
  logic                  load;

  always_ff @(posedge fast_clk_in) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = SHIFT;
      SHIFT:   state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  ser_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_counter (
    .clk        (fast_clk_in),
    .clear      (reset),
    .restart    (state == IDLE),
    .last_bit   (last_bit),
    .first_half (first_half)
  );

  // A new word is sampled on the first active edge and on every terminal-count edge.
  assign load = (state == IDLE) || last_bit;

  always_ff @(posedge fast_clk_in) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= bus.data_in;
    end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
      shift_reg <= shift_reg >> 1;
`else
      shift_reg <= shift_reg << 1;
`endif
    end
  end

  // IDLE is only reachable through reset, which clears shift_reg, so the tap is already 0 there.
`ifdef SERIALIZER_LSB_FIRST_EN
  assign bus.serial_out = shift_reg[0];
`else
  assign bus.serial_out = shift_reg[DATA_WIDTH-1];
`endif
  assign bus.done         = last_bit;
  assign bus.slow_clk_out = first_half;

endmodule

// File: tb/tb_data_serializer.sv
// Self-checking bench for data_serializer: directed words plus a bit-position reference model.
module tb_data_serializer;
  import serializer_pkg::*;

  localparam int W = SER_DATA_WIDTH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic cmp_en = 1'b0;

  data_serializer_if #(.DATA_WIDTH(W)) bus ();

  data_serializer #(.DATA_WIDTH(W)) dut (
    .fast_clk_in (clk),
    .reset       (reset),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which bit of which sampled word is on the line, tracked as a position in the word.
  logic         m_active = 1'b0;
  int           m_pos    = 0;
  logic [W-1:0] m_word   = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
    end else if (!m_active || m_pos == W - 1) begin
      m_word   = bus.data_in;
      m_pos    = 0;
      m_active = 1'b1;
    end else begin
      m_pos = m_pos + 1;
    end
  end

  function automatic logic exp_serial();
    if (!m_active) return 1'b0;
`ifdef SERIALIZER_LSB_FIRST_EN
    return m_word[m_pos];
`else
    return m_word[W - 1 - m_pos];
`endif
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model serial_out", 64'(bus.serial_out), 64'(exp_serial()));
      check("model done", 64'(bus.done), 64'(m_active && m_pos == W - 1));
      check("model slow_clk_out", 64'(bus.slow_clk_out), 64'(m_active && m_pos < W / 2));
    end
  end

  // Capture one word cycle by cycle; optionally change data_in mid-word, and drive next_val on done.
  task automatic capture_word(input int mid_cycle, input logic [W-1:0] mid_val,
                              input logic [W-1:0] next_val, input logic rst_on_done,
                              output logic [W-1:0] word, output logic [W-1:0] slow_bits,
                              output int done_cycle, output int done_count, output logic first_bit);
    word       = '0;
    slow_bits  = '0;
    done_cycle = -1;
    done_count = 0;
    first_bit  = 1'b0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) first_bit = bus.serial_out;
`ifdef SERIALIZER_LSB_FIRST_EN
      word = {bus.serial_out, word[W-1:1]};
`else
      word = {word[W-2:0], bus.serial_out};
`endif
      slow_bits = {slow_bits[W-2:0], bus.slow_clk_out};
      if (i == mid_cycle) bus.data_in = mid_val;
      if (bus.done) begin
        done_cycle = i;
        done_count++;
        if (rst_on_done) reset = 1'b1;
        else             bus.data_in = next_val;
      end
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] word, input logic [W-1:0] exp,
                            input int done_cycle, input int done_count);
    check({name, " word"}, 64'(word), 64'(exp));
    check({name, " done cycle"}, 64'(done_cycle), 64'(W));
    check({name, " done count"}, 64'(done_count), 64'd1);
  endtask

  logic [W-1:0] word;
  logic [W-1:0] slow_bits;
  int           done_cycle;
  int           done_count;
  logic         first_bit;
  int           idle_done;

  initial begin
    bus.data_in = 24'hFFFFFF;

    // Reset hold: outputs pinned to idle.
    @(posedge clk);
    #1 cmp_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("reset serial_out", 64'(bus.serial_out), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset slow_clk_out", 64'(bus.slow_clk_out), 64'd0);
    end

    bus.data_in = 24'hA5C3F0;
    reset       = 1'b0;
    capture_word(0, '0, 24'h000001, 1'b0, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w1", word, 24'hA5C3F0, done_cycle, done_count);
    check("w1 slow pattern", 64'(slow_bits), 64'hFFF000);
`ifdef SERIALIZER_LSB_FIRST_EN
    check("w1 first bit", 64'(first_bit), 64'd0);
`else
    check("w1 first bit", 64'(first_bit), 64'd1);
`endif

    capture_word(0, '0, 24'h800000, 1'b0, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w2", word, 24'h000001, done_cycle, done_count);
`ifdef SERIALIZER_LSB_FIRST_EN
    check("w2 first bit", 64'(first_bit), 64'd1);
`else
    check("w2 first bit", 64'(first_bit), 64'd0);
`endif

    capture_word(0, '0, 24'h123456, 1'b0, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w3", word, 24'h800000, done_cycle, done_count);

    // data_in changed at cycle 5 must not disturb the word in flight.
    capture_word(5, 24'hFEDCBA, 24'hFEDCBA, 1'b0, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w4 midchange", word, 24'h123456, done_cycle, done_count);

    capture_word(0, '0, 24'h5A5A5A, 1'b0, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w5", word, 24'hFEDCBA, done_cycle, done_count);

    // Reset during cycle 10: word abandoned, no done.
    idle_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.done) idle_done++;
    end
    reset       = 1'b1;
    bus.data_in = 24'h0F0F0F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort serial_out", 64'(bus.serial_out), 64'd0);
      check("abort slow_clk_out", 64'(bus.slow_clk_out), 64'd0);
      if (bus.done) idle_done++;
    end
    check("abort no done", 64'(idle_done), 64'd0);

    reset = 1'b0;
    capture_word(0, '0, '0, 1'b1, word, slow_bits, done_cycle, done_count, first_bit);
    check_word("w6 after abort", word, 24'h0F0F0F, done_cycle, done_count);

    // Reset on the done cycle: done was seen above, reload suppressed.
    bus.data_in = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done-reset serial_out", 64'(bus.serial_out), 64'd0);
      check("done-reset done", 64'(bus.done), 64'd0);
      check("done-reset slow_clk_out", 64'(bus.slow_clk_out), 64'd0);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
